// File: rtl/button_debouncer_nch.sv
// rtl/button_debouncer_nch.sv - multi-channel button debouncer with press/release/auto-repeat pulses
// Each channel: 2-FF synchronizer, stability filter, registered one-cycle event pulses.
module button_debouncer_nch #(
  parameter int CHANNELS      = 8,
  parameter int STABLE_CYCLES = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] sw_i,
  output logic [CHANNELS-1:0] sw_state_o,
  output logic [CHANNELS-1:0] sw_down_o,
  output logic [CHANNELS-1:0] sw_up_o,
  output logic [CHANNELS-1:0] sw_repeat_o
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int HMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HCNT_W = $clog2(HMAX + 1);

  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HCNT_W-1:0]   DELAY_LAST  = HCNT_W'(REPEAT_DELAY - 1);
  localparam logic [HCNT_W-1:0]   PERIOD_LAST = HCNT_W'(REPEAT_PERIOD - 1);
  localparam logic                IDLE_LVL    = (ACTIVE_LOW != 0);
  localparam logic [CHANNELS-1:0] IDLE_PIN    = {CHANNELS{IDLE_LVL}};

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] s;

  // Synchronizer resets to the released pin level so no press is seen at reset release.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ IDLE_PIN;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              first_done_q, first_done_d;
    logic              state_q, state_d;
    logic              down_q, down_d;
    logic              up_q, up_d;
    logic              repeat_q, repeat_d;

    always_comb begin
      cnt_d        = cnt_q;
      hcnt_d       = hcnt_q;
      first_done_d = first_done_q;
      state_d      = state_q;
      down_d       = 1'b0;
      up_d         = 1'b0;
      repeat_d     = 1'b0;

      if (s[g] == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = s[g];
        down_d  = s[g];
        up_d    = ~s[g];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Hold timer is held at zero whenever the accepted level is (or becomes) released,
      // and on the press-acceptance cycle, so a pending repeat never fires past release.
      if (REPEAT_EN != 0) begin
        if (!state_d || down_d) begin
          hcnt_d       = '0;
          first_done_d = 1'b0;
        end else if (hcnt_q == (first_done_q ? PERIOD_LAST : DELAY_LAST)) begin
          hcnt_d       = '0;
          first_done_d = 1'b1;
          repeat_d     = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        cnt_q        <= '0;
        hcnt_q       <= '0;
        first_done_q <= 1'b0;
        state_q      <= 1'b0;
        down_q       <= 1'b0;
        up_q         <= 1'b0;
        repeat_q     <= 1'b0;
      end else begin
        cnt_q        <= cnt_d;
        hcnt_q       <= hcnt_d;
        first_done_q <= first_done_d;
        state_q      <= state_d;
        down_q       <= down_d;
        up_q         <= up_d;
        repeat_q     <= repeat_d;
      end
    end

    assign sw_state_o[g]  = state_q;
    assign sw_down_o[g]   = down_q;
    assign sw_up_o[g]     = up_q;
    assign sw_repeat_o[g] = repeat_q;
  end

endmodule

// File: tb/tb_button_debouncer_nch.sv
// tb/tb_button_debouncer_nch.sv - table-driven bench for button_debouncer_nch
// Cycle c is sampled 1ns after posedge c-1; stimulus "at c" is applied just before posedge c.
module tb_button_debouncer_nch;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] sw_i;
  logic [3:0] sw_state_o, sw_down_o, sw_up_o, sw_repeat_o;

  button_debouncer_nch #(
    .CHANNELS(4), .STABLE_CYCLES(8), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sw_i(sw_i),
    .sw_state_o(sw_state_o), .sw_down_o(sw_down_o),
    .sw_up_o(sw_up_o), .sw_repeat_o(sw_repeat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    int         cyc;
    logic [3:0] sw;
  } stim_t;

  typedef struct {
    int         ph;
    int         cyc;
    logic [3:0] down;
    logic [3:0] up;
    logic [3:0] rpt;
  } exp_t;

  stim_t stims[$];
  exp_t  exps[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input int ph, input int c,
                     input logic [3:0] act, input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s phase %0d cycle %0d: got %b want %b", nm, ph, c, act, want);
    end
  endtask

  task automatic chk_all(input int ph, input int c, input logic [3:0] st,
                         input logic [3:0] d, input logic [3:0] u, input logic [3:0] r);
    chk("state",  ph, c, sw_state_o,  st);
    chk("down",   ph, c, sw_down_o,   d);
    chk("up",     ph, c, sw_up_o,     u);
    chk("repeat", ph, c, sw_repeat_o, r);
  endtask

  task automatic run_phase(input int ph, input int ncyc, input int rst_cyc, input bit keep_sw);
    logic [3:0] st_exp, d, u, r;
    rst_i = 1'b0;
    if (!keep_sw) sw_i = 4'hF;
    for (int k = 0; k < rst_cyc; k++) begin
      @(posedge clk); #1;
      chk_all(ph, -1 - k, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_i  = 1'b1;
    st_exp = 4'h0;
    for (int c = 0; c < ncyc; c++) begin
      d = 4'h0; u = 4'h0; r = 4'h0;
      foreach (exps[i]) begin
        if (exps[i].ph == ph && exps[i].cyc == c) begin
          d |= exps[i].down;
          u |= exps[i].up;
          r |= exps[i].rpt;
        end
      end
      st_exp = (st_exp | d) & ~u;
      chk_all(ph, c, st_exp, d, u, r);
      foreach (stims[i]) begin
        if (stims[i].ph == ph && stims[i].cyc == c) sw_i = stims[i].sw;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_i = 1'b0;
    sw_i  = 4'hF;

    // 1: clean press on ch0
    stims.push_back('{1, 0, 4'b1110});
    exps.push_back('{1, 10, 4'b0001, 4'b0000, 4'b0000});
    // 2: ch1 bounces every 3 cycles, final low edge at cycle 30
    for (int k = 0; k <= 10; k++)
      stims.push_back('{2, 3 * k, (k % 2 == 0) ? 4'b1101 : 4'b1111});
    exps.push_back('{2, 40, 4'b0010, 4'b0000, 4'b0000});
    // 3: ch2 held, auto-repeat, release at 42
    stims.push_back('{3, 0, 4'b1011});
    stims.push_back('{3, 42, 4'b1111});
    exps.push_back('{3, 10, 4'b0100, 4'b0000, 4'b0000});
    for (int k = 0; k < 5; k++)
      exps.push_back('{3, 30 + 5 * k, 4'b0000, 4'b0000, 4'b0100});
    exps.push_back('{3, 52, 4'b0000, 4'b0100, 4'b0000});
    // 4: simultaneous ch0+ch3 press, then ch1 release and ch2 press 4 cycles later
    stims.push_back('{4, 0, 4'b1101});
    stims.push_back('{4, 20, 4'b0100});
    stims.push_back('{4, 24, 4'b0010});
    exps.push_back('{4, 10, 4'b0010, 4'b0000, 4'b0000});
    exps.push_back('{4, 30, 4'b1001, 4'b0000, 4'b0010});
    exps.push_back('{4, 34, 4'b0100, 4'b0010, 4'b0000});
    // 5/6: ch0 held and repeating, then 1-cycle reset with button still held
    stims.push_back('{5, 0, 4'b1110});
    exps.push_back('{5, 10, 4'b0001, 4'b0000, 4'b0000});
    exps.push_back('{5, 30, 4'b0000, 4'b0000, 4'b0001});
    exps.push_back('{5, 35, 4'b0000, 4'b0000, 4'b0001});
    exps.push_back('{6, 10, 4'b0001, 4'b0000, 4'b0000});
    exps.push_back('{6, 30, 4'b0000, 4'b0000, 4'b0001});

    run_phase(0, 100, 3, 1'b0);
    run_phase(1, 25, 3, 1'b0);
    run_phase(2, 55, 3, 1'b0);
    run_phase(3, 80, 3, 1'b0);
    run_phase(4, 48, 3, 1'b0);
    run_phase(5, 37, 3, 1'b0);
    run_phase(6, 34, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer_nch.md
# button_debouncer_nch

Parametrised multi-channel successor to the single-button debouncer. Debounces `CHANNELS` independent mechanical inputs (push buttons or toggle switches). Each channel has a 2-FF synchronizer, a programmable stability filter, one-cycle press/release pulses and an optional hold-to-repeat pulse. The block sits between board pins and counter/display logic, so that logic can use synchronous pulses instead of clocking on button edges.

## Interface
- `CHANNELS`, 8, number of independent inputs (≥1)
- `STABLE_CYCLES`, 50000, consecutive identical samples required to accept a level (≥2)
- `ACTIVE_LOW`, 1, 1: pressed = pin low; 0: pressed = pin high
- `REPEAT_EN`, 1, 1: enable auto-repeat; 0: `sw_repeat_o` tied to 0
- `REPEAT_DELAY`, 25000000, cycles from press acceptance to first repeat pulse (≥1)
- `REPEAT_PERIOD`, 5000000, cycles between subsequent repeat pulses (≥1)

Ports:
- `clk_i`  in  1  system clock; the only clock
- `rst_i`  in  1  reset, synchronous, active-low
- `sw_i`  in  CHANNELS  raw asynchronous pin levels
- `sw_state_o`  out  CHANNELS  debounced level, 1 = pressed
- `sw_down_o`  out  CHANNELS  one-cycle pulse on accepted press
- `sw_up_o`  out  CHANNELS  one-cycle pulse on accepted release
- `sw_repeat_o`  out  CHANNELS  one-cycle pulse while held (auto-repeat)

## Operation
- Per channel, fully independent. No shared state except clock and reset.
- Synchronizer: 2 FFs. The output `s` is normalised so 1 = pressed (inverted when `ACTIVE_LOW`=1).
- Filter counter `cnt`, width `$clog2(STABLE_CYCLES)`:
  - When `s == state`, `cnt` is set to 0. Any glitch restarts the count.
  - When `s != state` and `cnt < STABLE_CYCLES-1`, `cnt` increments.
  - When `s != state` and `cnt == STABLE_CYCLES-1`, then `state <= s` and `cnt <= 0`. In the same cycle, `sw_down_o` is raised if `s`=1 or `sw_up_o` if `s`=0.
- Pulses are registered. Each is high for exactly one cycle, in the same cycle that `sw_state_o` changes.
- Hold counter `hcnt`, width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`, used only if `REPEAT_EN`:
  - It is 0 while `state`=0 and in the acceptance cycle of a press.
  - While pressed, it counts cycles. At `REPEAT_DELAY` cycles after `sw_down_o` it pulses `sw_repeat_o` and reloads. After that it pulses every `REPEAT_PERIOD` cycles.
  - `sw_down_o` never coincides with `sw_repeat_o`.
- Release acceptance clears `hcnt` in the same cycle. `sw_repeat_o` is 0 in the `sw_up_o` cycle and afterwards, even if a repeat was due.
- Simultaneous events on different channels appear in the same cycle in the corresponding bits.

## Timing
- Reset (`rst_i`=0 sampled at a `clk_i` edge):
  - Synchronizer FFs load the released level.
  - `state`, `cnt`, `hcnt` are 0.
  - All outputs are 0 from the next cycle.
  - No spurious pulse at reset release, even if pins are idle.
- Press/release latency: a pin change settled before edge 0 produces `sw_state_o` change and pulse in cycle `STABLE_CYCLES+2`.
- Minimum accepted pulse width on a pin is `STABLE_CYCLES` cycles. Shorter activity produces no output.
- Reset mid-operation: all state is dropped. If a button is still held at reset release, a fresh press is accepted at cycle `STABLE_CYCLES+2` after deassertion, and repeat timing restarts from that point.
- Wrap-around is not possible: `cnt` and `hcnt` saturate or reload before their maxima.

## Test plan
Configuration for all scenarios: `CHANNELS`=4, `STABLE_CYCLES`=8, `ACTIVE_LOW`=1, `REPEAT_EN`=1, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.

- Reset: hold `rst_i`=0 for 3 cycles with `sw_i`=4'hF, then release and run 100 cycles. Required: all outputs 0 throughout; no pulses.
- Clean press: `sw_i[0]` goes 1→0 before edge 0. Required: `sw_down_o`=4'b0001 in cycle 10 only; `sw_state_o[0]`=1 from cycle 10.
- Bounce: toggle `sw_i[1]` every 3 cycles for 30 cycles, then hold low. Required: no pulses during bounce; exactly one `sw_down_o[1]` pulse 10 cycles after the last edge.
- Auto-repeat and release: hold `sw_i[2]` low from cycle 0, then release at cycle 42.
  - `sw_down_o[2]` at cycle 10.
  - `sw_repeat_o[2]` at cycles 30, 35, 40, 45, 50.
  - `sw_up_o[2]` at cycle 52.
  - No repeat pulse at or after cycle 52.
- Simultaneous: press ch0 and ch3 in the same cycle, while ch1 releases and ch2 presses 4 cycles later. Required: `sw_down_o`=4'b1001 in one cycle; ch1 `sw_up_o` and ch2 `sw_down_o` 4 cycles after that, independent of each other.
- Reset mid-hold: ch0 held and repeating, assert `rst_i`=0 for 1 cycle, button kept low. Required: outputs 0 next cycle; `sw_down_o[0]` 10 cycles after deassertion; first repeat 20 cycles later.
